// File: rtl/ahb_lite_sram_slave_pkg.sv
// Shared AHB-Lite constants, slave FSM state type and access-decode helpers
// for the ahb_lite_sram_slave memory slave.
package ahb_lite_sram_slave_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } slv_state_t;

  // Oversized transfers and misaligned half/word transfers are rejected.
  function automatic logic access_illegal(input logic [2:0] size, input logic [1:0] lsb);
    logic bad;
    case (size)
      HSIZE_BYTE: bad = 1'b0;
      HSIZE_HALF: bad = lsb[0];
      HSIZE_WORD: bad = (lsb != 2'b00);
      default:    bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Little-endian byte-lane enables for a legal transfer.
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] lsb);
    logic [3:0] mask;
    case (size)
      HSIZE_BYTE: mask = 4'b0001 << lsb;
      HSIZE_HALF: mask = lsb[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: mask = 4'b1111;
      default:    mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/ahb_lite_sram_slave_core.sv
// Word-organised SRAM array: synchronous byte-enabled write, asynchronous read.
// Contents are deliberately not reset.
module ahb_lite_sram_slave_core
  import ahb_lite_sram_slave_pkg::*;
#(
  parameter int MEM_AW = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [MEM_AW-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [MEM_AW-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**MEM_AW];

  // Commit enabled byte lanes of the write word.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM slave top: address-phase capture, legality check, response FSM,
// optional wait-state counter and read-data register.
// Optional feature macro: AHB_SLV_WAIT_EN (compiles in WAIT_STATES counter and S_WAIT).
module ahb_lite_sram_slave
  import ahb_lite_sram_slave_pkg::*;
#(
  parameter int MEM_AW      = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  slv_state_t        state_q, state_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [3:0]        lanes_q, lanes_d;
  logic [31:0]       hrdata_q, hrdata_d;
  logic              hreadyout_q, hreadyout_d;
  logic              hresp_q, hresp_d;

  logic              accept_s;
  logic [MEM_AW-1:0] haddr_word_s;
  logic [MEM_AW-1:0] rd_addr_s;
  logic              rd_write_s;
  logic [31:0]       mem_rdata_s;
  logic              mem_we_s;
  logic              unused_bits;

`ifdef AHB_SLV_WAIT_EN
  logic [3:0] cnt_q, cnt_d;
  assign unused_bits = ^{HBURST, HTRANS[0], HADDR[31:MEM_AW+2]};
`else
  assign unused_bits = ^{HBURST, HTRANS[0], HADDR[31:MEM_AW+2], 1'(WAIT_STATES)};
`endif

  assign accept_s     = HSEL & HREADY & HTRANS[1];
  assign haddr_word_s = HADDR[MEM_AW+1:2];
  // Write lands on the edge that ends its ready data cycle.
  assign mem_we_s     = (state_q == S_DATA) & write_q;

  ahb_lite_sram_slave_core #(.MEM_AW(MEM_AW)) u_core (
    .clk   (HCLK),
    .we    (mem_we_s),
    .be    (lanes_q),
    .waddr (addr_q),
    .wdata (HWDATA),
    .raddr (rd_addr_s),
    .rdata (mem_rdata_s)
  );

  // Next-state, address-phase capture and read-data load.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    write_d     = write_q;
    lanes_d     = lanes_q;
    hrdata_d    = hrdata_q;
    rd_addr_s   = addr_q;
    rd_write_s  = write_q;
`ifdef AHB_SLV_WAIT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      S_IDLE, S_DATA, S_ERR2: begin
        if (accept_s) begin
          addr_d     = haddr_word_s;
          write_d    = HWRITE;
          lanes_d    = lane_mask(HSIZE, HADDR[1:0]);
          rd_addr_s  = haddr_word_s;
          rd_write_s = HWRITE;
          if (access_illegal(HSIZE, HADDR[1:0])) begin
            state_d = S_ERR1;
            write_d = 1'b0;
          end else begin
`ifdef AHB_SLV_WAIT_EN
            if (WAIT_STATES != 0) begin
              state_d = S_WAIT;
              cnt_d   = 4'd0;
            end else begin
              state_d = S_DATA;
            end
`else
            state_d = S_DATA;
`endif
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
`ifdef AHB_SLV_WAIT_EN
        if (cnt_q == 4'(WAIT_STATES - 1)) begin
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
`else
        state_d = S_IDLE;
`endif
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase

    // Load read data for the upcoming ready cycle, forwarding a write
    // that commits on the same edge to the same word.
    if ((state_d == S_DATA) && !rd_write_s) begin
      hrdata_d = mem_rdata_s;
      if (mem_we_s && (addr_q == rd_addr_s)) begin
        for (int b = 0; b < 4; b++) begin
          if (lanes_q[b]) begin
            hrdata_d[8*b +: 8] = HWDATA[8*b +: 8];
          end
        end
      end
    end else begin
      hrdata_d = hrdata_q;
    end

    hreadyout_d = !((state_d == S_WAIT) || (state_d == S_ERR1));
    hresp_d     = (state_d == S_ERR1) || (state_d == S_ERR2);
  end

  // State, pipeline and output registers.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      write_q     <= 1'b0;
      lanes_q     <= 4'b0000;
      hrdata_q    <= 32'h0000_0000;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      lanes_q     <= lanes_d;
      hrdata_q    <= hrdata_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
    end
  end

`ifdef AHB_SLV_WAIT_EN
  // Wait-state counter.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = hrdata_q;

endmodule
